// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute stage.
package ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  typedef enum logic [1:0] {
    FWD_IDEX,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Contents of the EX/MEM pipeline register.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] branch_target;
    logic [4:0]  rd;
    logic        branch_taken;
    logic        mem_read;
    logic        mem_write;
    logic        mem2reg;
    logic        reg_write;
  } exmem_t;

  // EX/MEM wins over MEM/WB; x0 is never forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_exmem,
    input logic       rw_exmem,
    input logic [4:0] rd_memwb,
    input logic       rw_memwb
  );
    if (rw_exmem && (rd_exmem != 5'd0) && (rd_exmem == rs))
      return FWD_EXMEM;
    else if (rw_memwb && (rd_memwb != 5'd0) && (rd_memwb == rs))
      return FWD_MEMWB;
    else
      return FWD_IDEX;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational 32-bit ALU for the execute stage.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  // Operation select; shifts use b[4:0], compares yield 0 or 1.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'd0, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU decode, branch resolution and EX/MEM register.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] read_data1_IDEX,
  input  logic [31:0] read_data2_IDEX,
  input  logic [31:0] PC_IDEX,
  input  logic [31:0] imm_IDEX,
  input  logic [31:0] instruc_IDEX,
  input  logic [4:0]  rd_IDEX,
  input  logic        branch_IDEX,
  input  logic        memRead_IDEX,
  input  logic        mem2reg_IDEX,
  input  logic        memWrite_IDEX,
  input  logic        ALUSrc_IDEX,
  input  logic        RegWrite_IDEX,
  input  logic [1:0]  ALUOp_IDEX,
  input  logic [4:0]  rd_MEMWB,
  input  logic        RegWrite_MEMWB,
  input  logic [31:0] write_Data_MEMWB,
  output logic [31:0] alu_result_EXMEM,
  output logic [31:0] write_data_EXMEM,
  output logic [31:0] branch_target_EXMEM,
  output logic [4:0]  rd_EXMEM,
  output logic        branch_taken_EXMEM,
  output logic        memRead_EXMEM,
  output logic        memWrite_EXMEM,
  output logic        mem2reg_EXMEM,
  output logic        RegWrite_EXMEM
);

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic        unused_instr_bits;

  fwd_sel_t    fwd_a_sel;
  fwd_sel_t    fwd_b_sel;
  logic [31:0] op_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  alu_op_t     alu_op;
  logic [31:0] alu_res;
  logic [31:0] br_target;
  logic        br_cond;
  logic        br_taken;

  exmem_t      exmem_d;
  exmem_t      exmem_q;

  assign rs1       = instruc_IDEX[19:15];
  assign rs2       = instruc_IDEX[24:20];
  assign funct3    = instruc_IDEX[14:12];
  assign funct7_b5 = instruc_IDEX[30];
  assign unused_instr_bits = ^{instruc_IDEX[31], instruc_IDEX[29:25], instruc_IDEX[11:0]};

  assign fwd_a_sel = fwd_select(rs1, exmem_q.rd, exmem_q.reg_write, rd_MEMWB, RegWrite_MEMWB);
  assign fwd_b_sel = fwd_select(rs2, exmem_q.rd, exmem_q.reg_write, rd_MEMWB, RegWrite_MEMWB);

  // Forwarding muxes for both operands; store data always takes forwarded rs2.
  always_comb begin
    op_a = read_data1_IDEX;
    case (fwd_a_sel)
      FWD_EXMEM: op_a = exmem_q.alu_result;
      FWD_MEMWB: op_a = write_Data_MEMWB;
      default:   op_a = read_data1_IDEX;
    endcase
    fwd_b = read_data2_IDEX;
    case (fwd_b_sel)
      FWD_EXMEM: fwd_b = exmem_q.alu_result;
      FWD_MEMWB: fwd_b = write_Data_MEMWB;
      default:   fwd_b = read_data2_IDEX;
    endcase
    op_b = ALUSrc_IDEX ? imm_IDEX : fwd_b;
  end

  // ALU operation decode from ALUOp, funct3 and funct7[5].
  always_comb begin
    alu_op = ALU_ADD;
    case (ALUOp_IDEX)
      ALUOP_ADD: alu_op = ALU_ADD;
      ALUOP_SUB: alu_op = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_op = ((ALUOp_IDEX == ALUOP_RTYPE) && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
    endcase
  end

  ex_stage_alu u_alu (
    .op     (alu_op),
    .a      (op_a),
    .b      (op_b),
    .result (alu_res)
  );

  assign br_target = PC_IDEX + imm_IDEX;

  // Branch condition on the forwarded register operands.
  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond = (op_a == fwd_b);
      F3_BNE:  br_cond = (op_a != fwd_b);
      F3_BLT:  br_cond = ($signed(op_a) <  $signed(fwd_b));
      F3_BGE:  br_cond = ($signed(op_a) >= $signed(fwd_b));
      F3_BLTU: br_cond = (op_a <  fwd_b);
      F3_BGEU: br_cond = (op_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
    br_taken = branch_IDEX & br_cond;
  end

  // Next EX/MEM contents: flush beats stall, stall holds, otherwise load.
  always_comb begin
    exmem_d = exmem_q;
    if (flush) begin
      exmem_d = '0;
    end else if (!stall) begin
      exmem_d.alu_result    = alu_res;
      exmem_d.write_data    = fwd_b;
      exmem_d.branch_target = br_target;
      exmem_d.rd            = rd_IDEX;
      exmem_d.branch_taken  = br_taken;
      exmem_d.mem_read      = memRead_IDEX;
      exmem_d.mem_write     = memWrite_IDEX;
      exmem_d.mem2reg       = mem2reg_IDEX;
      exmem_d.reg_write     = RegWrite_IDEX;
    end
  end

  // EX/MEM register with synchronous reset overriding stall and flush.
  always_ff @(posedge clk) begin
    if (rst) exmem_q <= '0;
    else     exmem_q <= exmem_d;
  end

  assign alu_result_EXMEM    = exmem_q.alu_result;
  assign write_data_EXMEM    = exmem_q.write_data;
  assign branch_target_EXMEM = exmem_q.branch_target;
  assign rd_EXMEM            = exmem_q.rd;
  assign branch_taken_EXMEM  = exmem_q.branch_taken;
  assign memRead_EXMEM       = exmem_q.mem_read;
  assign memWrite_EXMEM      = exmem_q.mem_write;
  assign mem2reg_EXMEM       = exmem_q.mem2reg;
  assign RegWrite_EXMEM      = exmem_q.reg_write;

endmodule
